uart_echo_ctrl: RTL and testbench

Sequencing controller that sits between the UART core's receive FIFO and transmit FIFO in place of the push-button loopback. Whenever a received byte is available, it pops one byte, forms a response, and pushes that response into the transmit FIFO.
- Clean byte: response is the byte plus a fixed increment.
- Parity error: response is a NAK code.
- Errored bytes are counted in a saturating counter for the LED/seven-segment debug display.

---
 rtl/uart_echo_pkg.sv | 14 +
 rtl/uart_echo_ctrl_sat_counter.sv | 23 ++
 rtl/uart_echo_ctrl.sv | 90 +++++++++
 tb/tb_uart_echo_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and defaults for the UART echo controller.
// State encoding and default response constants live here.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [7:0]  NAK_DEFAULT = 8'h15;
    localparam int unsigned INC_DEFAULT = 1;

endpackage

// File: rtl/uart_echo_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// RX-FIFO to TX-FIFO echo sequencer with parity-error counting.
// Define UART_ECHO_DROP_ERR_EN to drop errored bytes instead of sending NAK.
module uart_echo_ctrl
    import uart_echo_pkg::*;
#(
    parameter int unsigned INC       = INC_DEFAULT,
    parameter logic [7:0]  NAK_BYTE  = NAK_DEFAULT,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clr_cnt,
    input  logic                 rx_empty,
    input  logic [7:0]           r_data,
    input  logic                 error,
    output logic                 rd_uart,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [7:0] INC8 = INC[7:0];

    state_t     state;
    state_t     state_next;
    logic [7:0] data_q;
    logic       err_q;
    logic [7:0] resp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            data_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            // capture on the same edge that pops the FIFO head
            if (state == FETCH) begin
                data_q <= r_data;
                err_q  <= error;
            end
        end
    end

    always_comb begin
        state_next = state;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (enable && !rx_empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                rd_uart = 1'b1;
`ifdef UART_ECHO_DROP_ERR_EN
                state_next = error ? IDLE : SEND;
`else
                state_next = SEND;
`endif
            end
            SEND: begin
                if (!tx_full) begin
                    wr_uart    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp   = err_q ? NAK_BYTE : (data_q + INC8);
    assign w_data = (state == SEND) ? resp : 8'h00;

    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_cnt),
        .inc  ((state == FETCH) && error),
        .q    (err_count)
    );

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed self-checking bench for uart_echo_ctrl.
// Models the RX FIFO as an array and logs every TX push.
module tb_uart_echo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clr_cnt;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       error;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       busy;
    logic [7:0] err_count;

    logic [8:0] mem [0:1023];
    int head = 0;
    int tail = 0;
    int cyc  = 0;
    int tx_n = 0;
    logic [7:0] tx_d [0:1023];
    int tx_c [0:1023];
    int both_v = 0;
    int full_v = 0;
    int emp_v  = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rx_empty = (head == tail);
    assign r_data   = mem[head][7:0];
    assign error    = mem[head][8];

    uart_echo_ctrl #(
        .INC      (1),
        .NAK_BYTE (8'h15),
        .ERR_CNT_W(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clr_cnt  (clr_cnt),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .error    (error),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .busy     (busy),
        .err_count(err_count)
    );

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rd_uart) head <= head + 1;
        if (wr_uart) begin
            tx_d[tx_n] = w_data;
            tx_c[tx_n] = cyc;
            tx_n = tx_n + 1;
        end
        if (rd_uart && wr_uart) both_v++;
        if (wr_uart && tx_full) full_v++;
        if (rd_uart && rx_empty) emp_v++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic e, input logic [7:0] d);
        mem[tail] = {e, d};
        tail = tail + 1;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_n < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(tag, tx_n, n);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int k = 0;
        while ((head != tail || busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (head == tail) && !busy, 1);
    endtask

    int n0;
    int pc;

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        clr_cnt = 1'b0;
        tx_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd", rd_uart, 0);
        chk("rst_wr", wr_uart, 0);
        chk("rst_wdata", w_data, 8'h00);
        chk("rst_errcnt", err_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // clean byte 0x41 -> 0x42, latency 3 edges from push
        enable = 1'b1;
        n0 = tx_n;
        pc = cyc;
        push(1'b0, 8'h41);
        wait_tx(n0 + 1, "a_wr");
        chk("a_data", tx_d[n0], 8'h42);
        chk("a_lat", tx_c[n0] - pc, 3);
        chk("a_pop", head, tail);
        @(negedge clk);
        chk("a_busy", busy, 0);

        // wrap 0xFF -> 0x00
        n0 = tx_n;
        push(1'b0, 8'hFF);
        wait_tx(n0 + 1, "b_wr");
        chk("b_data", tx_d[n0], 8'h00);
        wait_idle(20, "b_idle");

        // parity error byte
        n0 = tx_n;
        push(1'b1, 8'h10);
`ifdef UART_ECHO_DROP_ERR_EN
        repeat (10) @(negedge clk);
        chk("c_nowr", tx_n, n0);
`else
        wait_tx(n0 + 1, "c_wr");
        chk("c_nak", tx_d[n0], 8'h15);
`endif
        wait_idle(20, "c_idle");
        chk("c_errcnt", err_count, 1);

        // TX back-pressure for 5 cycles
        tx_full = 1'b1;
        n0 = tx_n;
        push(1'b0, 8'h30);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("d_wr_low", wr_uart, 0);
            chk("d_wdata", w_data, 8'h31);
        end
        chk("d_busy", busy, 1);
        tx_full = 1'b0;
        wait_tx(n0 + 1, "d_wr");
        chk("d_data", tx_d[n0], 8'h31);
        repeat (5) @(negedge clk);
        chk("d_single", tx_n, n0 + 1);

        // enable dropped during the first SEND
        n0 = tx_n;
        push(1'b0, 8'h01);
        push(1'b0, 8'h02);
        push(1'b0, 8'h03);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("e_send", busy, 1);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("e_one", tx_n, n0 + 1);
        chk("e_d0", tx_d[n0], 8'h02);
        chk("e_left", tail - head, 2);
        chk("e_idle", busy, 0);
        enable = 1'b1;
        wait_tx(n0 + 3, "e_rest");
        chk("e_d1", tx_d[n0 + 1], 8'h03);
        chk("e_d2", tx_d[n0 + 2], 8'h04);
        chk("e_gap", (tx_c[n0 + 2] - tx_c[n0 + 1]) >= 3, 1);
        wait_idle(20, "e_done");

        // reset while stalled in SEND
        tx_full = 1'b1;
        n0 = tx_n;
        push(1'b0, 8'h55);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("f_stall", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("f_busy", busy, 0);
        chk("f_wr", wr_uart, 0);
        chk("f_errcnt", err_count, 0);
        reset   = 1'b0;
        tx_full = 1'b0;
        repeat (6) @(negedge clk);
        chk("f_notx", tx_n, n0);

        // 260 errored bytes saturate the counter
        for (int i = 0; i < 260; i++) push(1'b1, 8'(i));
        wait_idle(3000, "g_drain");
        chk("g_sat", err_count, 8'hFF);

        // clear in the same cycle as an error fetch
        push(1'b1, 8'h77);
        @(negedge clk);
        chk("h_fetch", rd_uart, 1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("h_clr", err_count, 0);
        wait_idle(20, "h_idle");
        chk("h_stay", err_count, 0);
        push(1'b1, 8'h78);
        wait_idle(20, "h_idle2");
        chk("h_inc", err_count, 1);

        chk("rd_wr_overlap", both_v, 0);
        chk("wr_when_full", full_v, 0);
        chk("rd_when_empty", emp_v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
